// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl shared definitions: mstatus fields, privilege
// encodings, interrupt causes and the sequencer state type.
package trap_ctrl_pkg;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_RETURN,
        ST_REDIRECT
    } trap_state_e;

    // Privilege restored by MRET; the reserved MPP encoding drops to U.
    function automatic logic [1:0] mret_priv(input logic [1:0] mpp);
        logic [1:0] p;
        case (mpp)
            PRIV_M:  p = PRIV_M;
            PRIV_S:  p = PRIV_S;
            default: p = PRIV_U;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl bus: exception/interrupt requests and CSR context in,
// CSR update values, redirect, privilege and stall out.
interface trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            exc_en;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_val;
    logic [XLEN-1:0] pc_addr;
    logic            mret;
    logic            irq_timer;
    logic            irq_ext;
    logic [XLEN-1:0] mstatus_current;
    logic [XLEN-1:0] mtvec_trap;
    logic [XLEN-1:0] mepc_current;
    logic [1:0]      priv_lvl;

    logic            trap_taken;
    logic            trap_done;
    logic [XLEN-1:0] mepc_next;
    logic [XLEN-1:0] mcause_next;
    logic [XLEN-1:0] mtval_next;
    logic [XLEN-1:0] mstatus_next;
    logic            pc_redirect_en;
    logic [XLEN-1:0] pc_redirect_addr;
    logic [1:0]      priv_lvl_next;
    logic            stall;

    modport master (
        output exc_en, exc_code, exc_val, pc_addr, mret,
        output irq_timer, irq_ext, mstatus_current,
        output mtvec_trap, mepc_current, priv_lvl,
        input  trap_taken, trap_done, mepc_next, mcause_next,
        input  mtval_next, mstatus_next, pc_redirect_en,
        input  pc_redirect_addr, priv_lvl_next, stall
    );

    modport slave (
        input  exc_en, exc_code, exc_val, pc_addr, mret,
        input  irq_timer, irq_ext, mstatus_current,
        input  mtvec_trap, mepc_current, priv_lvl,
        output trap_taken, trap_done, mepc_next, mcause_next,
        output mtval_next, mstatus_next, pc_redirect_en,
        output pc_redirect_addr, priv_lvl_next, stall
    );
endinterface

// File: rtl/trap_ctrl_vec_calc.sv
// Trap vector target: mtvec base, offset by cause*4 only for
// interrupts in vectored mode. Modes 2/3 behave as direct.
module trap_vec_calc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit VEC_EN = 1'b1
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [3:0]      i_cause,
    input  logic            i_is_int,
    output logic [XLEN-1:0] o_target
);
    logic [XLEN-1:0] w_base;
    logic            w_vectored;

    assign w_base     = i_mtvec & ~XLEN'(3);
    assign w_vectored = VEC_EN && i_is_int
                        && (i_mtvec[1:0] == MTVEC_VECTORED);
    assign o_target   = w_vectored
                        ? w_base + (XLEN'(i_cause) << 2)
                        : w_base;
endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, interrupts and MRET,
// then emits CSR updates, a PC redirect and a pipeline stall.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter bit         VEC_EN     = 1'b1,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);
    trap_state_e     r_state;
    logic            r_trap_taken;
    logic            r_trap_done;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mstatus;
    logic            r_redir_en;
    logic [XLEN-1:0] r_redir_addr;
    logic [XLEN-1:0] r_target;
    logic [1:0]      r_priv;
    logic            r_stall;

    logic            w_int_en;
    logic            w_irq;
    logic [3:0]      w_irq_cause;
    logic [3:0]      w_cause;
    logic            w_is_int;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_mst_enter;
    logic [XLEN-1:0] w_mst_ret;
    logic [XLEN-1:0] w_mcause;
    logic [XLEN-1:0] w_mtval;
    logic [1:0]      w_mpp;

    // Interrupts are always live below M; in M they need MIE.
    assign w_int_en    = (bus.priv_lvl != PRIV_M)
                         | bus.mstatus_current[MS_MIE];
    assign w_irq       = w_int_en & (bus.irq_ext | bus.irq_timer);
    assign w_irq_cause = bus.irq_ext ? CAUSE_MEI : CAUSE_MTI;
    assign w_is_int    = ~bus.exc_en & w_irq;
    assign w_cause     = bus.exc_en ? bus.exc_code : w_irq_cause;
    assign w_mpp       = bus.mstatus_current[MS_MPP_HI:MS_MPP_LO];

    assign w_mcause = w_is_int
        ? {1'b1, {(XLEN-5){1'b0}}, w_cause}
        : {{(XLEN-4){1'b0}}, w_cause};
    assign w_mtval  = w_is_int ? '0 : bus.exc_val;

    trap_vec_calc #(
        .XLEN   (XLEN),
        .VEC_EN (VEC_EN)
    ) u_vec (
        .i_mtvec  (bus.mtvec_trap),
        .i_cause  (w_cause),
        .i_is_int (w_is_int),
        .o_target (w_trap_target)
    );

    // mstatus image on trap entry: stack MIE into MPIE, record priv.
    always_comb begin
        w_mst_enter = bus.mstatus_current;
        w_mst_enter[MS_MPIE] = bus.mstatus_current[MS_MIE];
        w_mst_enter[MS_MIE]  = 1'b0;
        w_mst_enter[MS_MPP_HI:MS_MPP_LO] = bus.priv_lvl;
    end

    // mstatus image on MRET: restore MIE, re-arm MPIE, clear MPP.
    always_comb begin
        w_mst_ret = bus.mstatus_current;
        w_mst_ret[MS_MIE]  = bus.mstatus_current[MS_MPIE];
        w_mst_ret[MS_MPIE] = 1'b1;
        w_mst_ret[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
    end

    // Sequencer with registered outputs; pulses last one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_trap_taken <= 1'b0;
            r_trap_done  <= 1'b0;
            r_mepc       <= '0;
            r_mcause     <= '0;
            r_mtval      <= '0;
            r_mstatus    <= '0;
            r_redir_en   <= 1'b0;
            r_redir_addr <= '0;
            r_target     <= '0;
            r_priv       <= RESET_PRIV;
            r_stall      <= 1'b0;
        end else begin
            r_trap_taken <= 1'b0;
            r_trap_done  <= 1'b0;
            r_redir_en   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.exc_en | w_irq) begin
                        r_trap_taken <= 1'b1;
                        r_mepc    <= bus.pc_addr & ~XLEN'(3);
                        r_mcause  <= w_mcause;
                        r_mtval   <= w_mtval;
                        r_mstatus <= w_mst_enter;
                        r_priv    <= PRIV_M;
                        r_target  <= w_trap_target;
                        r_stall   <= 1'b1;
                        r_state   <= ST_ENTER;
                    end else if (bus.mret) begin
                        r_trap_done <= 1'b1;
                        r_mstatus <= w_mst_ret;
                        r_priv    <= mret_priv(w_mpp);
                        r_target  <= bus.mepc_current & ~XLEN'(3);
                        r_stall   <= 1'b1;
                        r_state   <= ST_RETURN;
                    end else begin
                        r_stall <= 1'b0;
                    end
                end
                ST_ENTER, ST_RETURN: begin
                    r_redir_en   <= 1'b1;
                    r_redir_addr <= r_target;
                    r_state      <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trap_taken       = r_trap_taken;
    assign bus.trap_done        = r_trap_done;
    assign bus.mepc_next        = r_mepc;
    assign bus.mcause_next      = r_mcause;
    assign bus.mtval_next       = r_mtval;
    assign bus.mstatus_next     = r_mstatus;
    assign bus.pc_redirect_en   = r_redir_en;
    assign bus.pc_redirect_addr = r_redir_addr;
    assign bus.priv_lvl_next    = r_priv;
    assign bus.stall            = r_stall;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exceptions, vectored and masked
// interrupts, arbitration, MRET and reset mid-sequence.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(XLEN)) bus();

    trap_ctrl #(
        .XLEN       (XLEN),
        .VEC_EN     (1'b1),
        .RESET_PRIV (2'b11)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_req();
        bus.exc_en    = 1'b0;
        bus.irq_timer = 1'b0;
        bus.irq_ext   = 1'b0;
        bus.mret      = 1'b0;
    endtask

    task automatic ctx(input logic [63:0] pc,
                       input logic [63:0] mst,
                       input logic [63:0] mtvec,
                       input logic [1:0]  priv);
        bus.pc_addr         = pc;
        bus.mstatus_current = mst;
        bus.mtvec_trap      = mtvec;
        bus.priv_lvl        = priv;
    endtask

    // N+1 after a trap request, then N+2 redirect, N+3 stall low.
    task automatic trap_seq(input string tag,
                            input logic [63:0] mepc,
                            input logic [63:0] mcause,
                            input logic [63:0] mtval,
                            input logic [63:0] mst,
                            input logic [63:0] target);
        tick();
        no_req();
        chk({tag, ".taken"}, bus.trap_taken, 1);
        chk({tag, ".done"}, bus.trap_done, 0);
        chk({tag, ".mepc"}, bus.mepc_next, mepc);
        chk({tag, ".mcause"}, bus.mcause_next, mcause);
        chk({tag, ".mtval"}, bus.mtval_next, mtval);
        chk({tag, ".mstatus"}, bus.mstatus_next, mst);
        chk({tag, ".priv"}, bus.priv_lvl_next, 2'b11);
        chk({tag, ".stall1"}, bus.stall, 1);
        chk({tag, ".redir1"}, bus.pc_redirect_en, 0);
        tick();
        chk({tag, ".redir2"}, bus.pc_redirect_en, 1);
        chk({tag, ".addr"}, bus.pc_redirect_addr, target);
        chk({tag, ".taken2"}, bus.trap_taken, 0);
        chk({tag, ".stall2"}, bus.stall, 1);
        tick();
        chk({tag, ".stall3"}, bus.stall, 0);
        chk({tag, ".redir3"}, bus.pc_redirect_en, 0);
    endtask

    logic [63:0] ret_mst [3];
    logic [63:0] ret_mepc[3];
    logic [63:0] ret_exp [3];
    logic [63:0] ret_tgt [3];
    logic [1:0]  ret_priv[3];

    initial begin
        no_req();
        ctx(64'h0, 64'h0, 64'h0, PRIV_M);
        bus.exc_code     = 4'd0;
        bus.exc_val      = 64'h0;
        bus.mepc_current = 64'h0;

        // reset state
        tick();
        tick();
        chk("rst.taken", bus.trap_taken, 0);
        chk("rst.done", bus.trap_done, 0);
        chk("rst.redir", bus.pc_redirect_en, 0);
        chk("rst.stall", bus.stall, 0);
        chk("rst.mepc", bus.mepc_next, 0);
        chk("rst.priv", bus.priv_lvl_next, 2'b11);
        rst = 1'b1;
        tick();
        chk("idle.stall", bus.stall, 0);

        // illegal instruction from M
        ctx(64'h8000_0104, 64'h8, 64'h8000_0000, PRIV_M);
        bus.exc_en   = 1'b1;
        bus.exc_code = 4'd2;
        bus.exc_val  = 64'hDEAD;
        trap_seq("ill", 64'h8000_0104, 64'd2, 64'hDEAD,
                 64'h1880, 64'h8000_0000);

        // vectored timer interrupt from U, misaligned pc
        ctx(64'h8000_0203, 64'hA_0000_0000, 64'h8000_0001, PRIV_U);
        bus.irq_timer = 1'b1;
        bus.exc_val   = 64'h1234;
        trap_seq("tmr", 64'h8000_0200, 64'h8000_0000_0000_0007,
                 64'h0, 64'hA_0000_0000, 64'h8000_001C);

        // external interrupt masked in M with MIE=0
        ctx(64'h8000_0400, 64'h0, 64'h8000_0001, PRIV_M);
        bus.irq_ext = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mask.taken", bus.trap_taken, 0);
            chk("mask.stall", bus.stall, 0);
            chk("mask.redir", bus.pc_redirect_en, 0);
        end
        bus.mstatus_current = 64'h8;
        trap_seq("ext", 64'h8000_0400, 64'h8000_0000_0000_000B,
                 64'h0, 64'h1880, 64'h8000_002C);

        // exception beats interrupt and mret
        ctx(64'h8000_0300, 64'h8, 64'h8000_0001, PRIV_M);
        bus.exc_en   = 1'b1;
        bus.exc_code = 4'd13;
        bus.exc_val  = 64'hBEEF;
        bus.irq_ext  = 1'b1;
        bus.mret     = 1'b1;
        trap_seq("sim", 64'h8000_0300, 64'd13, 64'hBEEF,
                 64'h1880, 64'h8000_0000);

        // MRET: plain, reserved MPP, MPP=S
        ret_mst  = '{64'h80, 64'h1000, 64'h888};
        ret_mepc = '{64'h8000_0200, 64'h8000_0206, 64'h8000_0100};
        ret_exp  = '{64'h88, 64'h80, 64'h88};
        ret_tgt  = '{64'h8000_0200, 64'h8000_0204, 64'h8000_0100};
        ret_priv = '{2'b00, 2'b00, 2'b01};
        for (int k = 0; k < 3; k++) begin
            ctx(64'h8000_0500, ret_mst[k], 64'h8000_0000, PRIV_M);
            bus.mepc_current = ret_mepc[k];
            bus.mret = 1'b1;
            tick();
            no_req();
            chk("mret.done", bus.trap_done, 1);
            chk("mret.taken", bus.trap_taken, 0);
            chk("mret.mstatus", bus.mstatus_next, ret_exp[k]);
            chk("mret.priv", bus.priv_lvl_next, ret_priv[k]);
            chk("mret.stall1", bus.stall, 1);
            tick();
            chk("mret.redir", bus.pc_redirect_en, 1);
            chk("mret.addr", bus.pc_redirect_addr, ret_tgt[k]);
            chk("mret.done2", bus.trap_done, 0);
            tick();
            chk("mret.stall3", bus.stall, 0);
        end

        // reset asserted while in ENTER
        ctx(64'h8000_0600, 64'h8, 64'h8000_0000, PRIV_M);
        bus.exc_en   = 1'b1;
        bus.exc_code = 4'd4;
        tick();
        no_req();
        chk("rmid.taken", bus.trap_taken, 1);
        rst = 1'b0;
        #1;
        chk("rmid.taken0", bus.trap_taken, 0);
        chk("rmid.stall", bus.stall, 0);
        chk("rmid.mepc", bus.mepc_next, 0);
        chk("rmid.mcause", bus.mcause_next, 0);
        chk("rmid.priv", bus.priv_lvl_next, 2'b11);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post.taken", bus.trap_taken, 0);
            chk("post.redir", bus.pc_redirect_en, 0);
            chk("post.stall", bus.stall, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer sitting directly downstream of the CSR top-level block.
- Consumes the exception report (exc_en/exc_code/exc_val), mstatus_current and mtvec_trap, plus core interrupt lines and MRET.
- Produces trap_taken, trap_done, mepc_next, mcause_next, mtval_next and mstatus_next for the machine CSR file.
- Also produces the PC redirect, the next privilege level and a pipeline stall.

Parameters:
- XLEN, 64, data/address width.
- VEC_EN, 1, 1 = honour mtvec vectored mode for interrupts; 0 = always direct.
- RESET_PRIV, 2'b11, privilege level after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- exc_en  in  1  synchronous exception from the current instruction.
- exc_code  in  4  exception cause code.
- exc_val  in  XLEN  faulting value; goes to mtval.
- pc_addr  in  XLEN  PC of the current instruction.
- mret  in  1  current instruction is MRET.
- irq_timer  in  1  machine timer interrupt pending (level).
- irq_ext  in  1  machine external interrupt pending (level).
- mstatus_current  in  XLEN  live mstatus.
- mtvec_trap  in  XLEN  live mtvec.
- mepc_current  in  XLEN  live mepc; used by MRET.
- priv_lvl  in  2  current privilege level.
- trap_taken  out  1  one-cycle pulse; CSR file latches mepc/mcause/mtval/mstatus_next.
- trap_done  out  1  one-cycle pulse on MRET; CSR file latches mstatus_next.
- mepc_next, mcause_next, mtval_next, mstatus_next  out  XLEN each  CSR update values.
- pc_redirect_en  out  1  one-cycle pulse; fetch loads pc_redirect_addr.
- pc_redirect_addr  out  XLEN  redirect target.
- priv_lvl_next  out  2  registered privilege level.
- stall  out  1  hold pipeline.

Behaviour:
- **FSM states:** IDLE, ENTER, RETURN, REDIRECT. All outputs registered.
- **Reset (rst=0, async):**
  - State returns to IDLE; any in-flight sequence is aborted, with no pulse emitted later.
  - All XLEN and 1-bit outputs go to 0; priv_lvl_next goes to RESET_PRIV.
- **Interrupt enable:**
  - int_en = (priv_lvl != 2'b11) | mstatus_current[3].
  - Interrupt request = int_en & (irq_ext | irq_timer).
  - Ext wins over timer: cause 11 vs 7.
- **IDLE arbitration, sampled each cycle:**
  - Priority is exc_en > interrupt > mret.
  - exc_en or interrupt → capture cause, value, pc_addr and priv_lvl; go to ENTER; stall=1 next cycle.
  - mret → go to RETURN; stall=1.
  - Otherwise remain in IDLE with stall=0.
- **ENTER (1 cycle), trap_taken=1:**
  - mepc_next = {pc_addr[XLEN-1:2], 2'b00}.
  - Exception: mcause_next = zero-extended exc_code with bit63=0; mtval_next = exc_val.
  - Interrupt: mcause_next = bit63=1 | cause; mtval_next = 0.
  - mstatus_next = mstatus_current with MPIE[7] ← MIE[3], MIE[3] ← 0, MPP[12:11] ← captured priv.
  - priv_lvl_next ← 2'b11.
  - Go to REDIRECT.
- **Redirect target on trap:**
  - base = {mtvec_trap[XLEN-1:2], 2'b00}.
  - If VEC_EN and mtvec_trap[1:0]==2'b01 and interrupt: base + (cause << 2). Otherwise base.
  - mtvec modes 2 and 3 are treated as direct.
- **RETURN (1 cycle), trap_done=1:**
  - mstatus_next: MIE ← MPIE, MPIE ← 1, MPP ← 2'b00.
  - priv_lvl_next ← old MPP; MPP=2'b10 (reserved) maps to 2'b00.
  - Target = {mepc_current[XLEN-1:2], 2'b00}.
  - Go to REDIRECT.
- **REDIRECT (1 cycle):** pc_redirect_en=1 with the latched target, stall=1; then IDLE.
- **Latency:**
  - Trap: request in cycle N → trap_taken at N+1 → redirect at N+2 → stall drops at N+3.
  - MRET: same timing.
- **Ignored inputs:** exc_en, irqs and mret are ignored outside IDLE. No queuing; the pipeline is stalled and must re-present them.
- **Pulse exclusivity:** trap_taken, trap_done and pc_redirect_en are never asserted in the same cycle.

Decomposition:
- Shared package holds:
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - Privilege encodings U/S/M.
  - Interrupt cause constants (MTI=7, MEI=11).
  - FSM state enum.
- Sub-module trap_vec_calc (combinational): mtvec + cause + is_interrupt → target address.

Test Plan:
- **Illegal-instruction exception:** pc_addr=0x8000_0104, exc_en=1, exc_code=2, exc_val=0xDEAD, priv=M, mtvec=0x8000_0000 → N+1: trap_taken, mepc_next=0x8000_0104, mcause_next=2, mtval_next=0xDEAD, MPP=11, MIE=0. N+2: redirect 0x8000_0000.
- **Vectored timer interrupt from U-mode:** mtvec=0x8000_0001, irq_timer=1, priv=U, MIE=0 → mcause_next=0x8000_0000_0000_0007, mtval_next=0, redirect 0x8000_001C, priv_lvl_next=11.
- **Masked interrupt:** priv=M, MIE=0, irq_ext=1 for 10 cycles → no pulses, stall=0. Setting MIE=1 → cause 11 taken.
- **Simultaneous requests:** exc_en=1, irq_ext=1 and mret=1 in the same cycle → exception cause recorded; no trap_done.
- **MRET:** mstatus MPIE=1, MPP=00, mepc_current=0x8000_0200 → trap_done, mstatus_next MIE=1, MPIE=1, MPP=00, priv_lvl_next=00, redirect 0x8000_0200.
- **Reset mid-sequence:** assert rst=0 while in ENTER → outputs cleared immediately, priv_lvl_next=11. After release: no stale trap_taken or redirect.
